// File: rtl/vend_credit_fsm.sv
// ---------------------------------------------------------------------------
// vend_credit_fsm
//
// Credit/control stage of the vending datapath. Coin events accumulate into an
// 8-bit cent credit; a purchase request dispenses once the credit covers PRICE,
// and any remainder (or a cancelled credit) is returned one nickel per cycle.
// credit_d/credit_en drive the downstream enabled credit/display register.
//
// All outputs are registered: the response to the inputs sampled on a rising
// clock edge is visible for the cycle that follows that edge. The state a
// cycle is spent in and the outputs shown during it are loaded by the same
// edge, so dispense is high for the whole DISPENSE cycle, change_pulse for
// every CHANGE cycle that returns a nickel, and busy for both.
//
// Optional build macro: VEND_COIN_EDGE_EN
//   defined   - nickel/dime/quarter are raw button levels; a registered
//               rising-edge detector turns each press into one event
//               (one extra cycle of coin-to-credit latency).
//   undefined - each high cycle on a coin input is one coin event.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset        synchronous active-low reset
//   nickel       coin event, 5 cents
//   dime         coin event, 10 cents
//   quarter      coin event, 25 cents
//   vend_req     purchase request
//   cancel       refund request
//   credit_d     new credit value (downstream register d)
//   credit_en    load strobe, high on cycles where credit changed
//   dispense     one-cycle item-release pulse
//   change_pulse one pulse per 5 cents returned
//   coin_reject  one-cycle pulse when a coin event is refused
//   busy         high in DISPENSE and CHANGE
// ---------------------------------------------------------------------------
module vend_credit_fsm #(
  parameter logic [7:0] PRICE      = 8'd75,
  parameter logic [7:0] MAX_CREDIT = 8'd250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nickel,
  input  logic       dime,
  input  logic       quarter,
  input  logic       vend_req,
  input  logic       cancel,
  output logic [7:0] credit_d,
  output logic       credit_en,
  output logic       dispense,
  output logic       change_pulse,
  output logic       coin_reject,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CREDIT,
    S_DISPENSE,
    S_CHANGE
  } state_t;

  localparam logic [8:0] NICKEL_W = 9'd5;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] credit;
  logic [8:0] credit_nxt;
  logic       dispense_nxt;
  logic       change_nxt;
  logic       reject_nxt;
  logic       busy_nxt;

  logic       ev_n;
  logic       ev_d;
  logic       ev_q;
  logic [8:0] coin_sum;
  logic       coin_any;
  logic [8:0] credit_w;
  logic [8:0] sum_w;
  logic       sum_fits;

  // -------------------------------------------------------------------------
  // Coin event source
  // -------------------------------------------------------------------------
`ifdef VEND_COIN_EDGE_EN
  logic [2:0] lvl_q;
  logic [2:0] prev_q;

  // Both stages are registered so an event is a clean one-cycle pulse that is
  // independent of where the button edge falls within the cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lvl_q  <= '0;
      prev_q <= '0;
    end else begin
      lvl_q  <= {quarter, dime, nickel};
      prev_q <= lvl_q;
    end
  end

  assign {ev_q, ev_d, ev_n} = lvl_q & ~prev_q;
`else
  assign ev_n = nickel;
  assign ev_d = dime;
  assign ev_q = quarter;
`endif

  // Simultaneous events add up; 9 bits so credit + coins cannot wrap before
  // the ceiling comparison.
  always_comb begin
    coin_sum = (ev_n ? 9'd5  : 9'd0)
             + (ev_d ? 9'd10 : 9'd0)
             + (ev_q ? 9'd25 : 9'd0);
  end

  assign coin_any = (coin_sum != 9'd0);
  assign credit_w = {1'b0, credit};
  assign sum_w    = credit_w + coin_sum;
  assign sum_fits = (sum_w <= {1'b0, MAX_CREDIT});

  // -------------------------------------------------------------------------
  // Next-state / next-output logic
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    credit_nxt   = credit_w;
    dispense_nxt = 1'b0;
    change_nxt   = 1'b0;
    reject_nxt   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (coin_any) begin
          if (coin_sum <= {1'b0, MAX_CREDIT}) begin
            state_nxt  = S_CREDIT;
            credit_nxt = coin_sum;
          end else begin
            reject_nxt = 1'b1;
          end
        end
      end

      S_CREDIT: begin
        if (cancel) begin
          // First refund nickel goes out on the same edge that enters CHANGE.
          state_nxt  = S_CHANGE;
          credit_nxt = credit_w - NICKEL_W;
          change_nxt = 1'b1;
          reject_nxt = coin_any;
        end else if (vend_req && (credit_w >= {1'b0, PRICE})) begin
          state_nxt    = S_DISPENSE;
          credit_nxt   = credit_w - {1'b0, PRICE};
          dispense_nxt = 1'b1;
          reject_nxt   = coin_any;
        end else if (coin_any) begin
          if (sum_fits) begin
            credit_nxt = sum_w;
          end else begin
            reject_nxt = 1'b1;
          end
        end
      end

      S_DISPENSE: begin
        reject_nxt = coin_any;
        if (credit != 8'd0) begin
          state_nxt  = S_CHANGE;
          credit_nxt = credit_w - NICKEL_W;
          change_nxt = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end

      S_CHANGE: begin
        reject_nxt = coin_any;
        // The cycle that shows credit 0 is still CHANGE; leave on the next edge.
        if (credit != 8'd0) begin
          credit_nxt = credit_w - NICKEL_W;
          change_nxt = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt  = S_IDLE;
        credit_nxt = 9'd0;
      end
    endcase

    busy_nxt = (state_nxt == S_DISPENSE) || (state_nxt == S_CHANGE);
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      credit       <= 8'd0;
      credit_en    <= 1'b0;
      dispense     <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      credit       <= credit_nxt[7:0];
      credit_en    <= (credit_nxt[7:0] != credit);
      dispense     <= dispense_nxt;
      change_pulse <= change_nxt;
      coin_reject  <= reject_nxt;
      busy         <= busy_nxt;
    end
  end

  // credit only changes together with credit_en, so the credit register
  // already holds "new value when loaded, last value otherwise".
  assign credit_d = credit;

  // -------------------------------------------------------------------------
  // Credit range checks
  // -------------------------------------------------------------------------
  credit_ceiling_a : assert property (
    @(posedge clk) disable iff (!reset) credit <= MAX_CREDIT
  );

  // A wrap below zero on any subtraction sets bit 8 of the wide next value.
  credit_underflow_a : assert property (
    @(posedge clk) disable iff (!reset) !credit_nxt[8]
  );

endmodule

// File: doc/vend_credit_fsm.md
Name: vend_credit_fsm

Overview:
- Credit/control stage of the vending datapath; sits directly upstream of the 8-bit enabled display/credit register.
- Accumulates coin inputs into an 8-bit cent credit and dispenses on request once credit covers the price.
- Returns change one nickel per cycle.
- Produces a credit_d/credit_en pair that the downstream register captures (d/en).

Parameters:
- PRICE, 8'd75, item price in cents; a multiple of 5.
- MAX_CREDIT, 8'd250, credit ceiling in cents; a multiple of 5, and PRICE <= MAX_CREDIT <= 255.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset; state is cleared on a posedge clk while reset==0.
- nickel  input  1  coin event, 5 cents.
- dime  input  1  coin event, 10 cents.
- quarter  input  1  coin event, 25 cents.
- vend_req  input  1  purchase request.
- cancel  input  1  refund request.
- credit_d  output  8  new credit value, for the downstream register's d.
- credit_en  output  1  load strobe, for the downstream register's en.
- dispense  output  1  one-cycle item-release pulse.
- change_pulse  output  1  one pulse per 5 cents returned.
- coin_reject  output  1  one-cycle pulse when a coin event is refused.
- busy  output  1  high in DISPENSE and CHANGE.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, internal credit=0.
  - All outputs 0: credit_d=0, credit_en=0, dispense=0, change_pulse=0, coin_reject=0, busy=0.
  - Reset overrides every other input and aborts DISPENSE/CHANGE mid-operation; no further change pulses.
- Outputs are registered; every response appears on the cycle after the causing input edge.
- Coin value: coin_sum = 5*nickel + 10*dime + 25*quarter, summed across simultaneous events (max 40), computed at 9 bits.
- States and transitions:
  - IDLE: credit==0.
    - coin_sum>0 and coin_sum<=MAX_CREDIT: go to CREDIT.
    - vend_req and cancel are ignored.
  - CREDIT: credit>0. Priority is cancel > vend_req > coins.
    - cancel: go to CHANGE with refund=credit.
    - vend_req and credit>=PRICE: go to DISPENSE.
    - vend_req and credit<PRICE: ignored; coins are processed normally in that cycle.
    - Coins: if credit+coin_sum <= MAX_CREDIT, credit += coin_sum. Otherwise the whole event is refused: coin_reject=1 and credit is unchanged.
    - Coins arriving in the same cycle as an accepted cancel or vend are rejected (coin_reject=1).
  - DISPENSE (1 cycle):
    - dispense=1; credit -= PRICE.
    - Next state is CHANGE if the remainder is >0, else IDLE.
  - CHANGE:
    - Each cycle: change_pulse=1 and credit -= 5.
    - When credit reaches 0, go to IDLE the following cycle.
    - N cents of change gives exactly N/5 consecutive pulses.
- Coins in DISPENSE or CHANGE: rejected (coin_reject=1), credit unaffected. vend_req and cancel are ignored in these states.
- credit_en=1 exactly on cycles where the internal credit changes; credit_d equals the new value on those cycles.
  - The downstream register therefore mirrors credit with one further cycle of latency.
  - When credit_en=0, credit_d holds its last value.
- Credit never exceeds MAX_CREDIT and never underflows; both are checked by assertion.
- busy is high exactly in DISPENSE and CHANGE.

Optional Feature:
- Macro: VEND_COIN_EDGE_EN.
- Defined:
  - nickel, dime and quarter are treated as raw button levels.
  - Each is registered, and only a rising edge counts as an event; a held input counts once.
  - The edge-detect registers clear on reset.
  - Adds one cycle of coin-to-credit latency (2 cycles total).
- Undefined: inputs are single-cycle pulses, and every high cycle is one coin event.

Test Plan (VEND_COIN_EDGE_EN undefined unless noted):
- Reset, then quarter ×3 on separate cycles, then vend_req -> credit_d sequence 25, 50, 75 with credit_en each time; then dispense=1 for 1 cycle, credit_d=0, back to IDLE, no change_pulse.
- Quarter ×4 (credit 100), then vend_req -> dispense pulse, credit_d=25, then 5 consecutive change_pulse cycles with credit_d 20, 15, 10, 5, 0; busy high throughout.
- Dime + nickel together (15), then cancel -> 3 change_pulse cycles; dispense never asserted.
- Credit 250, then nickel -> coin_reject=1, credit_en=0, credit stays 250. vend_req at credit 50 -> no dispense, state unchanged.
- Credit 100, vend_req, then reset=0 during the 2nd change pulse -> next cycle all outputs 0, no further change_pulse.
- With VEND_COIN_EDGE_EN defined: quarter held high for 4 cycles -> credit 25 only, credit_en first asserted 2 cycles after the rising edge.
